// File: rtl/alu_exec_stage_if.sv
// Command and result handshake bundle for alu_exec_stage.
// slave = the stage side, master = the command source / result sink side.
interface alu_exec_stage_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       cmd_use_acc;

    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_zero;
    logic       res_carry;
    logic [3:0] res_op;
    logic       res_illegal;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, res_ready,
        output cmd_ready, res_valid, res_data, res_zero, res_carry, res_op, res_illegal
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, res_ready,
        input  cmd_ready, res_valid, res_data, res_zero, res_carry, res_op, res_illegal
    );
endinterface

// File: rtl/alu_exec_stage.sv
// Issue/capture stage around a combinational 8-bit ALU: IDLE -> EXEC -> RESP.
// Optional macro ALU_EXEC_ACC_FWD_EN lets cmd_use_acc replace operand A with the last ALU result.
module alu_exec_stage (
    input  logic                   clk,
    input  logic                   rst,
    alu_exec_stage_if.slave        bus,
    output logic [3:0]             alu_select,
    output logic [7:0]             alu_a_in,
    output logic [7:0]             alu_b_in,
    input  logic [7:0]             alu_out,
    input  logic                   alu_zero_flag,
    input  logic                   alu_carry_out,
    output logic                   err_illegal,
    output logic [7:0]             ops_done,
    output logic [1:0]             dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // cmd_ready and res_valid depend only on state (and rst), never on the peer's signal.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_next;
    logic   cmd_fire;
    logic   res_fire;
    logic   cur_illegal;

    function automatic logic op_is_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b1011, 4'b1100: op_is_legal = 1'b1;
            default:                                               op_is_legal = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next    = state;
        bus.cmd_ready = 1'b0;
        bus.res_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.cmd_ready = ~rst;
                if (bus.cmd_valid) state_next = EXEC;
            end
            EXEC: state_next = RESP;
            RESP: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign cmd_fire    = (state == IDLE) && bus.cmd_valid;
    assign res_fire    = (state == RESP) && bus.res_ready;
    assign cur_illegal = ~op_is_legal(alu_select);
    assign dbg_state   = state;

`ifdef ALU_EXEC_ACC_FWD_EN
    logic [7:0] acc;

    always_ff @(posedge clk) begin
        if (rst)                acc <= 8'h00;
        else if (state == EXEC) acc <= alu_out;
    end
`else
    logic unused_use_acc;
    assign unused_use_acc = bus.cmd_use_acc;
`endif

    // ALU-port registers only move on command acceptance and hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_select <= 4'h0;
            alu_a_in   <= 8'h00;
            alu_b_in   <= 8'h00;
        end else if (cmd_fire) begin
            alu_select <= bus.cmd_op;
            alu_b_in   <= bus.cmd_b;
`ifdef ALU_EXEC_ACC_FWD_EN
            alu_a_in   <= bus.cmd_use_acc ? acc : bus.cmd_a;
`else
            alu_a_in   <= bus.cmd_a;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.res_data    <= 8'h00;
            bus.res_zero    <= 1'b0;
            bus.res_carry   <= 1'b0;
            bus.res_op      <= 4'h0;
            bus.res_illegal <= 1'b0;
            err_illegal     <= 1'b0;
            ops_done        <= 8'h00;
        end else begin
            if (state == EXEC) begin
                bus.res_data    <= alu_out;
                bus.res_zero    <= alu_zero_flag;
                bus.res_carry   <= alu_carry_out;
                bus.res_op      <= alu_select;
                bus.res_illegal <= cur_illegal;
                if (cur_illegal) err_illegal <= 1'b1;
            end
            if (res_fire) ops_done <= ops_done + 8'd1;
        end
    end
endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with a small behavioural ALU attached to its ALU ports.
module tb_alu_exec_stage;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] alu_select;
  logic [7:0] alu_a_in;
  logic [7:0] alu_b_in;
  logic [7:0] alu_out;
  logic       alu_zero_flag;
  logic       alu_carry_out;
  logic       err_illegal;
  logic [7:0] ops_done;
  logic [1:0] dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  int exp_ops = 0;
  int lat;

  alu_exec_stage_if bus ();

  alu_exec_stage dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .alu_select    (alu_select),
    .alu_a_in      (alu_a_in),
    .alu_b_in      (alu_b_in),
    .alu_out       (alu_out),
    .alu_zero_flag (alu_zero_flag),
    .alu_carry_out (alu_carry_out),
    .err_illegal   (err_illegal),
    .ops_done      (ops_done),
    .dbg_state     (dbg_state)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: ADD reports carry only, SUB/NOR report zero, shifts report the bit shifted out.
  always_comb begin
    logic [8:0] wide;
    wide          = 9'h000;
    alu_out       = 8'h00;
    alu_zero_flag = 1'b0;
    alu_carry_out = 1'b0;
    case (alu_select)
      4'b0001: begin
        wide          = {1'b0, alu_a_in} + {1'b0, alu_b_in};
        alu_out       = wide[7:0];
        alu_carry_out = wide[8];
      end
      4'b0010: begin
        wide          = {1'b0, alu_a_in} - {1'b0, alu_b_in};
        alu_out       = wide[7:0];
        alu_carry_out = wide[8];
        alu_zero_flag = (wide[7:0] == 8'h00);
      end
      4'b0011: begin
        alu_out       = ~(alu_a_in | alu_b_in);
        alu_zero_flag = (alu_out == 8'h00);
      end
      4'b1011: begin
        alu_out       = alu_a_in >> 1;
        alu_carry_out = alu_a_in[0];
      end
      4'b1100: begin
        alu_out       = alu_a_in << 1;
        alu_carry_out = alu_a_in[7];
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic use_acc);
    int n;
    n = 0;
    @(negedge clk);
    bus.cmd_op      = op;
    bus.cmd_a       = a;
    bus.cmd_b       = b;
    bus.cmd_use_acc = use_acc;
    bus.cmd_valid   = 1'b1;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      check("cmd_accept_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      #1;
    end
    bus.cmd_valid = 1'b0;
  endtask

  // Counts negedges from just after acceptance until res_valid is seen.
  task automatic wait_result(output int cycles);
    cycles = 0;
    @(negedge clk);
    while (!bus.res_valid && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    if (!bus.res_valid) check("res_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic take_result();
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    exp_ops++;
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic use_acc, input logic [7:0] exp_data,
                        input logic exp_zero, input logic exp_carry, input logic exp_ill,
                        input logic full);
    int cyc;
    send_cmd(op, a, b, use_acc);
    wait_result(cyc);
    check({tag, "_data"}, bus.res_data, exp_data);
    if (full) begin
      check({tag, "_latency"}, cyc, 1);
      check({tag, "_zero"}, bus.res_zero, exp_zero);
      check({tag, "_carry"}, bus.res_carry, exp_carry);
      check({tag, "_op"}, bus.res_op, op);
      check({tag, "_illegal"}, bus.res_illegal, exp_ill);
    end
    take_result();
    if (full) check({tag, "_ops_done"}, ops_done, exp_ops & 255);
  endtask

  initial begin
    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = 4'h0;
    bus.cmd_a       = 8'h00;
    bus.cmd_b       = 8'h00;
    bus.cmd_use_acc = 1'b0;
    bus.res_ready   = 1'b0;
    rst             = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_res_valid", bus.res_valid, 0);
    rst = 1'b0;
    #1;
    check("post_rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_alu_select", alu_select, 0);
    check("rst_alu_a", alu_a_in, 0);
    check("rst_alu_b", alu_b_in, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_ops_done", ops_done, 0);
    check("rst_err_illegal", err_illegal, 0);

    run_op("add_ff", 4'b0001, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    run_op("sub_eq", 4'b0010, 8'h05, 8'h05, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    run_op("sub_neg", 4'b0010, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b1);
    run_op("shfl", 4'b1100, 8'h81, 8'h00, 1'b0, 8'h02, 1'b0, 1'b1, 1'b0, 1'b1);
    run_op("shfr", 4'b1011, 8'h81, 8'h00, 1'b0, 8'h40, 1'b0, 1'b1, 1'b0, 1'b1);
    run_op("nop", 4'b0000, 8'hAA, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure: result held while a new command waits.
    send_cmd(4'b0001, 8'h11, 8'h22, 1'b0);
    wait_result(lat);
    bus.cmd_op    = 4'b0010;
    bus.cmd_a     = 8'h09;
    bus.cmd_b     = 8'h01;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_res_valid", bus.res_valid, 1);
      check("bp_cmd_ready", bus.cmd_ready, 0);
      check("bp_alu_a", alu_a_in, 8'h11);
      check("bp_res_data", bus.res_data, 8'h33);
    end
    take_result();
    check("bp_alu_a_after_hs", alu_a_in, 8'h11);
    check("bp_ops_done", ops_done, exp_ops & 255);
    send_cmd(4'b0010, 8'h09, 8'h01, 1'b0);
    check("bp_alu_a_new", alu_a_in, 8'h09);
    wait_result(lat);
    check("bp_new_data", bus.res_data, 8'h08);
    take_result();

    run_op("acc_seed", 4'b0001, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef ALU_EXEC_ACC_FWD_EN
    run_op("acc_fwd", 4'b0001, 8'h00, 8'h01, 1'b1, 8'h31, 1'b0, 1'b0, 1'b0, 1'b1);
`else
    run_op("acc_fwd", 4'b0001, 8'h00, 8'h01, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

    run_op("illegal", 4'b0101, 8'h12, 8'h34, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    check("err_sticky_set", err_illegal, 1);
    run_op("nor_zero", 4'b0011, 8'h0F, 8'hF0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    check("err_sticky_hold", err_illegal, 1);

    // Counter wrap: bring ops_done to 255, then one more.
    while (exp_ops < 255) begin
      run_op("fill", 4'b0001, 8'(exp_ops), 8'h01, 1'b0, 8'(exp_ops + 1), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("ops_255", ops_done, 8'hFF);
    run_op("wrap_op", 4'b0001, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ops_wrap", ops_done, 8'h00);
    while (exp_ops < 511) begin
      run_op("fill2", 4'b0010, 8'(exp_ops), 8'h00, 1'b0, 8'(exp_ops), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("ops_255_again", ops_done, 8'hFF);

    // Reset while a result is pending in RESP.
    send_cmd(4'b0001, 8'h40, 8'h02, 1'b0);
    wait_result(lat);
    check("pre_rst_res_valid", bus.res_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_res_valid", bus.res_valid, 0);
    check("mid_rst_ops_done", ops_done, 0);
    check("mid_rst_err_illegal", err_illegal, 0);
    check("mid_rst_cmd_ready", bus.cmd_ready, 0);
    check("mid_rst_alu_a", alu_a_in, 0);
    rst = 1'b0;
    exp_ops = 0;
    #1;
    check("after_rst_cmd_ready", bus.cmd_ready, 1);
    @(negedge clk);
    check("after_rst_state_idle", dbg_state, 0);
    run_op("post_rst_add", 4'b0001, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    check("global_timeout", 32'd0, 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "global timeout");
  end
endmodule
